// File: rtl/load_store_unit_if.sv
// Byte-wide data-memory bus between the load/store unit and data memory.
//
// Handshake: the master raises exactly one of mem_re / mem_we together with
// mem_addr (and mem_wdata for writes) and holds all of them constant until a
// cycle in which mem_ready=1; that cycle completes the byte (mem_rdata is
// valid in that same cycle for reads). A strobe with mem_ready=0 is a wait
// state with no timeout.
interface load_store_unit_if #(
  parameter int MEM_AW = 12
);
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: performs LW/LH/LHU/LB/LBU/SW/SH/SB as a
// sequence of single-byte memory handshakes (little-endian), stalling the
// pipeline until the access finishes. Misaligned or illegal-size requests
// complete immediately with err and never touch memory.
module load_store_unit #(
  parameter int MEM_AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          read_part,
  input  logic [1:0]          write_part,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic                done,
  output logic                err,
  output logic [31:0]         rdata,
  load_store_unit_if.master   mem_bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;    // byte count minus one
  logic              load_q;
  logic              signed_q;
  logic [1:0]        k_q;
  logic              err_q;
  logic [31:0]       asm_q;
  logic [31:0]       rdata_q;

  logic              req_valid;
  logic [1:0]        req_last;
  logic              req_signed;
  logic              req_bad;
  logic [31:0]       asm_d;
  logic [31:0]       ext_d;
  logic              last_byte;

  // Upper address bits are outside the data memory's byte address range.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:MEM_AW];

  // Decode the incoming request: size, signedness, legality and alignment.
  always_comb begin
    req_valid  = start & (MemRead | MemWrite) & (state_q == S_IDLE);
    req_last   = 2'd0;
    req_signed = 1'b0;
    req_bad    = 1'b0;
    if (MemRead) begin
      case (read_part)
        3'd0:    req_last = 2'd3;
        3'd1:    begin req_last = 2'd1; req_signed = 1'b1; end
        3'd2:    req_last = 2'd1;
        3'd3:    begin req_last = 2'd0; req_signed = 1'b1; end
        3'd4:    req_last = 2'd0;
        default: req_bad = 1'b1;
      endcase
    end else begin
      case (write_part)
        2'd0:    req_last = 2'd3;
        2'd1:    req_last = 2'd1;
        2'd2:    req_last = 2'd0;
        default: req_bad = 1'b1;
      endcase
    end
    if ((req_last == 2'd3) && (addr[1:0] != 2'b00)) req_bad = 1'b1;
    if ((req_last == 2'd1) && addr[0])              req_bad = 1'b1;
  end

  // Merge the incoming byte into the assembly word and apply load extension.
  always_comb begin
    asm_d = asm_q;
    asm_d[{k_q, 3'b000} +: 8] = mem_bus.mem_rdata;
    case (last_q)
      2'd0:    ext_d = signed_q ? {{24{asm_d[7]}}, asm_d[7:0]}   : {24'd0, asm_d[7:0]};
      2'd1:    ext_d = signed_q ? {{16{asm_d[15]}}, asm_d[15:0]} : {16'd0, asm_d[15:0]};
      default: ext_d = asm_d;
    endcase
  end

  assign last_byte = (k_q == last_q);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = req_bad ? S_DONE : S_ACCESS;
      S_ACCESS: if (mem_bus.mem_ready && last_byte) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory strobes, pipeline stall and completion pulse.
  always_comb begin
    stall             = (state_q != S_IDLE) | req_valid;
    done              = (state_q == S_DONE);
    mem_bus.mem_re    = (state_q == S_ACCESS) & load_q;
    mem_bus.mem_we    = (state_q == S_ACCESS) & ~load_q;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = 8'd0;
    if (state_q == S_ACCESS) begin
      mem_bus.mem_addr = addr_q + MEM_AW'(k_q);
      if (!load_q) mem_bus.mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
    end
    dbg_state = state_q;
  end

  // Request latch, byte counter, load assembly and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      last_q   <= 2'd0;
      load_q   <= 1'b0;
      signed_q <= 1'b0;
      k_q      <= 2'd0;
      err_q    <= 1'b0;
      asm_q    <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= addr[MEM_AW-1:0];
            wdata_q  <= wdata;
            last_q   <= req_last;
            load_q   <= MemRead;
            signed_q <= req_signed;
            k_q      <= 2'd0;
            err_q    <= req_bad;
            asm_q    <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (mem_bus.mem_ready) begin
            asm_q <= asm_d;
            k_q   <= k_q + 2'd1;
            if (last_byte && load_q) rdata_q <= ext_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign err   = done & err_q;
  assign rdata = rdata_q;

endmodule
